// File: rtl/gate_result_pkg.sv
// Shared defaults and width helpers for the gate result buffer.
package gate_result_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDepth     = 4;

    // Occupancy needs one extra bit to represent the full value Depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gate_result_buffer.sv
// First-word fall-through result buffer: drops results when full and no pop is
// pending, and raises a sticky overflow flag until cleared or reset.
module gate_result_buffer
    import gate_result_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned Depth     = DefDepth
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          res_valid_i,
    input  logic [DataWidth-1:0]          res_data_i,
    input  logic                          clear_i,
    output logic                          valid_o,
    output logic [DataWidth-1:0]          data_o,
    input  logic                          ready_i,
    output logic [cnt_width(Depth)-1:0]   count_o,
    output logic                          overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 overflow_q, overflow_d;

    logic push, pop, full, accept, mem_we;

    assign push   = res_valid_i;
    assign pop    = valid_o & ready_i;
    assign full   = (count_q == CntW'(Depth));
    // A pop in the same cycle frees the slot the push needs.
    assign accept = push & (~full | pop);
    assign mem_we = accept & ~clear_i;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
            case ({accept, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
            if (push & full & ~pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= res_data_i;
    end

    assign valid_o    = (count_q != '0);
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: doc/gate_result_buffer.md
GATE_RESULT_BUFFER -- requirements
Module: gate_result_buffer

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of each buffered gate result.
REQ-002 SHALL have parameter Depth, default 4: number of entries, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port res_valid_i, input, 1 bit: producer result strobe, one result per high cycle; no backpressure.
REQ-006 SHALL have port res_data_i, input, DataWidth bits: producer result, sampled when res_valid_i=1.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous flush of all entries and clear of overflow.
REQ-008 SHALL have port valid_o, output, 1 bit: head entry available.
REQ-009 SHALL have port data_o, output, DataWidth bits: head entry (first-word fall-through).
REQ-010 SHALL have port ready_i, input, 1 bit: consumer accepts the head when valid_o and ready_i are both 1.
REQ-011 SHALL have port count_o, output, $clog2(Depth)+1 bits: current occupancy.
REQ-012 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a result was dropped.

Function
REQ-013 SHALL define push = res_valid_i and pop = valid_o and ready_i, both evaluated in the same cycle.
REQ-014 SHALL write res_data_i at the write pointer on push; the entry SHALL be visible on data_o/valid_o in the following cycle when the buffer was empty (latency 1).
REQ-015 SHALL drive valid_o = (count != 0) and data_o = mem[rd_ptr] combinationally from registers; data_o SHALL be don't-care when valid_o=0.
REQ-016 SHALL advance rd_ptr on pop and wr_ptr on an accepted push; pointers SHALL wrap from Depth-1 to 0.
REQ-017 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on push and pop together.
REQ-018 Full and push without pop: the result SHALL be dropped, stored data and pointers SHALL be unchanged, and overflow_o SHALL be set on the next edge.
REQ-019 Full and push with pop: the push SHALL be accepted, count SHALL stay at Depth, and overflow SHALL be unchanged.
REQ-020 Empty: pop is impossible since valid_o=0; push and ready_i together SHALL NOT bypass, and the result SHALL appear on the next cycle.
REQ-021 clear_i=1: count, rd_ptr and wr_ptr SHALL go to 0 and overflow_o to 0, with priority over push and pop in the same cycle; a coincident push SHALL be discarded and SHALL NOT set overflow.
REQ-022 overflow_o SHALL remain 1 until clear_i or rst_i.
REQ-023 data_o and count_o SHALL be glitch-free register-derived values, with no combinational path from res_valid_i or ready_i to any output.

Reset
REQ-024 rst_i=1 SHALL asynchronously force count_o=0, valid_o=0, overflow_o=0, rd_ptr=0 and wr_ptr=0.
REQ-025 Storage array contents SHALL NOT be reset and SHALL be don't-care after reset.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries, and no pop SHALL be reported in the reset-release cycle.
REQ-027 The first push SHALL be accepted on the first rising clk edge after rst_i deasserts.

Structure
REQ-028 SHALL use package gate_result_pkg holding the default DataWidth and Depth localparams and a function returning the count width for a given Depth.
REQ-029 SHALL be a single module with no sub-module; storage SHALL be a register array, and the pointers and count SHALL be inline always_ff logic.

Verification
REQ-030 Reset then push 0xA5A5_0001 with ready_i=0 -> next cycle valid_o=1, data_o=0xA5A5_0001, count_o=1.
REQ-031 Push 5 values 1..5 at Depth=4 with ready_i=0 -> count_o=4, overflow_o=1, then pops return 1,2,3,4 in order.
REQ-032 Full, then push 9 and pop together -> count_o stays 4, overflow_o stays 0, and pop order continues with 9 last.
REQ-033 Push 8 entries while popping every cycle -> pointers wrap, each value is seen exactly once in order, and count_o never exceeds 1.
REQ-034 With 3 entries and overflow_o=1, assert clear_i together with a push -> next cycle count_o=0, valid_o=0, overflow_o=0.
REQ-035 Assert rst_i asynchronously mid-stream with 2 entries -> outputs go to zero immediately without waiting for a clk edge.
